// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A granted producer keeps the port for up to MAX_BURST pushing beats.
//
// state | meaning
// IDLE  | no lock; winner searched from rr_ptr, first beat pushes immediately
// BURST | lock_idx owns the port until release, burst end or flush

module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_flush_o,
  output logic [IDX_W-1:0]              gnt_idx_o,
  output logic                          busy_o
);

  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("fifo_push_arbiter: NUM_REQ must be at least 2");
  end
  if (MAX_BURST < 1) begin : g_chk_max_burst
    $error("fifo_push_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy_q;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Rotating priority search; wrap handled explicitly so NUM_REQ need not be 2^n.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand_sum;

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req_valid_i[cand_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  logic [IDX_W-1:0] serve_idx;
  logic             push;

  always_comb begin
    serve_idx = (state == BURST) ? lock_idx : win_idx;
    if (flush_i || fifo_full_i) push = 1'b0;
    else if (state == BURST)    push = req_valid_i[lock_idx];
    else                        push = win_found;
  end

  always_comb begin
    req_ready_o = '0;
    if (push) req_ready_o[serve_idx] = 1'b1;
  end

  assign fifo_push_o  = push;
  assign fifo_data_o  = req_data[serve_idx];
  assign fifo_flush_o = flush_i;
  assign gnt_idx_o    = serve_idx;
  assign busy_o       = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      beat_cnt <= '0;
      busy_q   <= 1'b0;
    end else if (flush_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            if (MAX_BURST == 1) begin
              rr_ptr <= next_idx(win_idx);
            end else begin
              lock_idx <= win_idx;
              beat_cnt <= CNT_W'(1);
              state    <= BURST;
              busy_q   <= 1'b1;
            end
          end
        end
        BURST: begin
          if (!req_valid_i[lock_idx]) begin
            rr_ptr   <= next_idx(lock_idx);
            beat_cnt <= '0;
            state    <= IDLE;
            busy_q   <= 1'b0;
          end else if (!fifo_full_i) begin
            // Full-stall cycles never reach here, so only pushing beats count.
            if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
              rr_ptr   <= next_idx(lock_idx);
              beat_cnt <= '0;
              state    <= IDLE;
              busy_q   <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push_o && fifo_full_i));
  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_ready_o & ~req_valid_i) == '0);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus random
// traffic against a behavioural model, on MAX_BURST=4 and MAX_BURST=1 instances.

module tb_fifo_push_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic [N-1:0]  valid = '0;
  logic          full = 1'b0;
  logic [N*DW-1:0] req_data;
  logic [23:0]   seq [N];

  logic [N-1:0]  a_ready, b_ready;
  logic          a_push, b_push, a_flush, b_flush, a_busy, b_busy;
  logic [DW-1:0] a_data, b_data;
  logic [1:0]    a_gnt, b_gnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = {8'(k), seq[k]};
  end

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_valid_i(valid),
    .req_data_i(req_data), .req_ready_o(a_ready), .fifo_full_i(full),
    .fifo_push_o(a_push), .fifo_data_o(a_data), .fifo_flush_o(a_flush),
    .gnt_idx_o(a_gnt), .busy_o(a_busy));

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_valid_i(valid),
    .req_data_i(req_data), .req_ready_o(b_ready), .fifo_full_i(full),
    .fifo_push_o(b_push), .fifo_data_o(b_data), .fifo_flush_o(b_flush),
    .gnt_idx_o(b_gnt), .busy_o(b_busy));

  // Behavioural model: owner is the locked producer or -1, prio is the search start.
  typedef struct {
    int owner;
    int cnt;
    int prio;
  } mstate_t;

  mstate_t ms [2];

  function automatic int m_winner(mstate_t s, logic [N-1:0] v);
    if (s.owner >= 0) return v[s.owner] ? s.owner : -1;
    for (int i = 0; i < N; i++) begin
      int k = (s.prio + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic m_push(mstate_t s, logic [N-1:0] v, logic f, logic fl);
    return !fl && !f && (m_winner(s, v) >= 0);
  endfunction

  function automatic int m_gnt(mstate_t s, logic [N-1:0] v);
    int w = m_winner(s, v);
    if (s.owner >= 0) return s.owner;
    return (w >= 0) ? w : s.prio;
  endfunction

  function automatic mstate_t m_next(mstate_t s, logic [N-1:0] v, logic f, logic fl, int mb);
    mstate_t n = s;
    if (fl) begin
      n.owner = -1;
      n.cnt   = 0;
      return n;
    end
    if (s.owner < 0) begin
      if (m_push(s, v, f, fl)) begin
        if (mb == 1) n.prio = (m_winner(s, v) + 1) % N;
        else begin
          n.owner = m_winner(s, v);
          n.cnt   = 1;
        end
      end
    end else if (!v[s.owner]) begin
      n.prio  = (s.owner + 1) % N;
      n.owner = -1;
      n.cnt   = 0;
    end else if (!f) begin
      n.cnt = s.cnt + 1;
      if (n.cnt == mb) begin
        n.prio  = (s.owner + 1) % N;
        n.owner = -1;
        n.cnt   = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] onehot(int k);
    logic [N-1:0] r = '0;
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  // Producer data advances only when instance A accepts a beat from it.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ms[0] <= '{-1, 0, 0};
      ms[1] <= '{-1, 0, 0};
      for (int k = 0; k < N; k++) seq[k] <= '0;
    end else begin
      if (m_push(ms[0], valid, full, flush_i))
        seq[m_winner(ms[0], valid)] <= seq[m_winner(ms[0], valid)] + 24'd1;
      ms[0] <= m_next(ms[0], valid, full, flush_i, 4);
      ms[1] <= m_next(ms[1], valid, full, flush_i, 1);
    end
  end

  task automatic do_reset();
    flush_i = 1'b0;
    valid   = '0;
    full    = 1'b0;
    rst_ni  = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni  = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    #1;
    n_checks++; if (a_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready_a: got %b expected 0000", a_ready); end
    n_checks++; if (a_push !== 1'b0) begin n_fail++; $display("FAIL reset_push_a: got %b expected 0", a_push); end
    n_checks++; if (a_gnt !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_a: got %0d expected 0", a_gnt); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", a_busy); end
    n_checks++; if (a_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush_a: got %b expected 0", a_flush); end
    n_checks++; if (b_ready !== 4'b0 || b_push !== 1'b0 || b_gnt !== 2'd0 || b_busy !== 1'b0 || b_flush !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got ready=%b push=%b gnt=%0d busy=%b flush=%b expected all 0", b_ready, b_push, b_gnt, b_busy, b_flush);
    end
  endtask

  task automatic test_alternate();
    int exp_src [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
    int cnt [N];
    logic exp_busy;
    do_reset();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      valid = 4'b0101;
      #1;
      exp_busy = (c % 4) != 0;
      n_checks++; if (a_push !== 1'b1 || a_ready !== onehot(exp_src[c])) begin
        n_fail++; $display("FAIL alt_grant c=%0d: got push=%b ready=%b expected push=1 ready=%b", c, a_push, a_ready, onehot(exp_src[c]));
      end
      n_checks++; if (a_data !== {8'(exp_src[c]), 24'(cnt[exp_src[c]])}) begin
        n_fail++; $display("FAIL alt_data c=%0d: got %h expected %h", c, a_data, {8'(exp_src[c]), 24'(cnt[exp_src[c]])});
      end
      n_checks++; if (a_busy !== exp_busy) begin
        n_fail++; $display("FAIL alt_busy c=%0d: got %b expected %b", c, a_busy, exp_busy);
      end
      cnt[exp_src[c]]++;
    end
  endtask

  task automatic test_release();
    logic [N-1:0] v_tab [4] = '{4'b1010, 4'b1010, 4'b1000, 4'b1000};
    logic e_push [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int   e_src  [4] = '{1, 1, 1, 3};
    logic e_busy [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int   e_seq  [4] = '{0, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      valid = v_tab[c];
      #1;
      n_checks++; if (a_push !== e_push[c] || a_ready !== (e_push[c] ? onehot(e_src[c]) : 4'b0)) begin
        n_fail++; $display("FAIL rel_push c=%0d: got push=%b ready=%b expected push=%b", c, a_push, a_ready, e_push[c]);
      end
      n_checks++; if (a_gnt !== 2'(e_src[c]) || a_busy !== e_busy[c]) begin
        n_fail++; $display("FAIL rel_state c=%0d: got gnt=%0d busy=%b expected gnt=%0d busy=%b", c, a_gnt, a_busy, e_src[c], e_busy[c]);
      end
      if (e_push[c]) begin
        n_checks++; if (a_data !== {8'(e_src[c]), 24'(e_seq[c])}) begin
          n_fail++; $display("FAIL rel_data c=%0d: got %h expected %h", c, a_data, {8'(e_src[c]), 24'(e_seq[c])});
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic f_tab  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e_push [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   e_src  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic e_busy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   e_seq  [8] = '{0, 1, 1, 1, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      valid = 4'b0011;
      full  = f_tab[c];
      #1;
      n_checks++; if (a_push !== e_push[c] || a_ready !== (e_push[c] ? onehot(e_src[c]) : 4'b0)) begin
        n_fail++; $display("FAIL full_push c=%0d: got push=%b ready=%b expected push=%b", c, a_push, a_ready, e_push[c]);
      end
      n_checks++; if (a_gnt !== 2'(e_src[c]) || a_busy !== e_busy[c]) begin
        n_fail++; $display("FAIL full_state c=%0d: got gnt=%0d busy=%b expected gnt=%0d busy=%b", c, a_gnt, a_busy, e_src[c], e_busy[c]);
      end
      if (e_push[c]) begin
        n_checks++; if (a_data !== {8'(e_src[c]), 24'(e_seq[c])}) begin
          n_fail++; $display("FAIL full_data c=%0d: got %h expected %h", c, a_data, {8'(e_src[c]), 24'(e_seq[c])});
        end
      end
    end
    full = 1'b0;
  endtask

  task automatic test_flush();
    logic fl_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic e_push [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic e_busy [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int   e_seq  [4] = '{0, 1, 2, 2};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      valid   = 4'b0011;
      flush_i = fl_tab[c];
      #1;
      n_checks++; if (a_flush !== fl_tab[c] || b_flush !== fl_tab[c]) begin
        n_fail++; $display("FAIL flush_out c=%0d: got a=%b b=%b expected %b", c, a_flush, b_flush, fl_tab[c]);
      end
      n_checks++; if (a_push !== e_push[c] || a_ready !== (e_push[c] ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL flush_push c=%0d: got push=%b ready=%b expected push=%b", c, a_push, a_ready, e_push[c]);
      end
      n_checks++; if (a_gnt !== 2'd0 || a_busy !== e_busy[c]) begin
        n_fail++; $display("FAIL flush_state c=%0d: got gnt=%0d busy=%b expected gnt=0 busy=%b", c, a_gnt, a_busy, e_busy[c]);
      end
      if (e_push[c]) begin
        n_checks++; if (a_data !== {8'd0, 24'(e_seq[c])}) begin
          n_fail++; $display("FAIL flush_data c=%0d: got %h expected %h", c, a_data, {8'd0, 24'(e_seq[c])});
        end
      end
    end
    flush_i = 1'b0;
  endtask

  task automatic test_single_beat();
    int e_gnt [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      valid = 4'b1111;
      #1;
      n_checks++; if (b_gnt !== 2'(e_gnt[c]) || b_push !== 1'b1 || b_ready !== onehot(e_gnt[c])) begin
        n_fail++; $display("FAIL single_grant c=%0d: got gnt=%0d push=%b ready=%b expected gnt=%0d", c, b_gnt, b_push, b_ready, e_gnt[c]);
      end
      n_checks++; if (b_busy !== 1'b0) begin
        n_fail++; $display("FAIL single_busy c=%0d: got %b expected 0", c, b_busy);
      end
      n_checks++; if (b_data !== {8'(e_gnt[c]), seq[e_gnt[c]]}) begin
        n_fail++; $display("FAIL single_data c=%0d: got %h expected %h", c, b_data, {8'(e_gnt[c]), seq[e_gnt[c]]});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      valid = 4'b0010;
    end
    #1;
    n_checks++; if (a_busy !== 1'b1 || a_gnt !== 2'd1) begin
      n_fail++; $display("FAIL midrst_pre: got busy=%b gnt=%0d expected busy=1 gnt=1", a_busy, a_gnt);
    end
    valid  = 4'b0000;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (a_busy !== 1'b0 || a_gnt !== 2'd0 || a_push !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got busy=%b gnt=%0d push=%b expected busy=0 gnt=0 push=0", a_busy, a_gnt, a_push);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    mstate_t s;
    int w;
    logic e_push;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      valid   = 4'($urandom);
      full    = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic [N-1:0] r_ready;
        logic r_push, r_busy, r_flush;
        logic [1:0] r_gnt;
        logic [DW-1:0] r_data;
        s = ms[d];
        w = m_winner(s, valid);
        e_push = m_push(s, valid, full, flush_i);
        r_ready = (d == 0) ? a_ready : b_ready;
        r_push  = (d == 0) ? a_push  : b_push;
        r_busy  = (d == 0) ? a_busy  : b_busy;
        r_flush = (d == 0) ? a_flush : b_flush;
        r_gnt   = (d == 0) ? a_gnt   : b_gnt;
        r_data  = (d == 0) ? a_data  : b_data;
        n_checks++; if (r_push !== e_push || r_ready !== (e_push ? onehot(w) : 4'b0)) begin
          n_fail++; $display("FAIL rand_push dut=%0d c=%0d: got push=%b ready=%b expected push=%b ready=%b", d, c, r_push, r_ready, e_push, e_push ? onehot(w) : 4'b0);
        end
        n_checks++; if (r_gnt !== 2'(m_gnt(s, valid)) || r_busy !== (s.owner >= 0) || r_flush !== flush_i) begin
          n_fail++; $display("FAIL rand_state dut=%0d c=%0d: got gnt=%0d busy=%b flush=%b expected gnt=%0d busy=%b flush=%b", d, c, r_gnt, r_busy, r_flush, m_gnt(s, valid), s.owner >= 0, flush_i);
        end
        if (e_push) begin
          n_checks++; if (r_data !== {8'(w), seq[w]}) begin
            n_fail++; $display("FAIL rand_data dut=%0d c=%0d: got %h expected %h", d, c, r_data, {8'(w), seq[w]});
          end
        end
      end
    end
    flush_i = 1'b0;
    full    = 1'b0;
  endtask

  task automatic test_fairness();
    int last_a [N];
    int last_b [N];
    int gap_a = 0;
    int gap_b = 0;
    int pushes = 0;
    do_reset();
    for (int k = 0; k < N; k++) begin last_a[k] = -1; last_b[k] = -1; end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk_i);
      valid = 4'b1111;
      #1;
      if (a_push === 1'b1) pushes++;
      for (int k = 0; k < N; k++) begin
        if (a_ready[k] === 1'b1) begin
          if (c - last_a[k] - 1 > gap_a) gap_a = c - last_a[k] - 1;
          last_a[k] = c;
        end
        if (b_ready[k] === 1'b1) begin
          if (c - last_b[k] - 1 > gap_b) gap_b = c - last_b[k] - 1;
          last_b[k] = c;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (64 - last_a[k] - 1 > gap_a) gap_a = 64 - last_a[k] - 1;
      if (64 - last_b[k] - 1 > gap_b) gap_b = 64 - last_b[k] - 1;
    end
    n_checks++; if (gap_a > (N - 1) * 4) begin n_fail++; $display("FAIL fair_wait_a: got %0d cycles expected at most %0d", gap_a, (N - 1) * 4); end
    n_checks++; if (gap_b > (N - 1) * 1) begin n_fail++; $display("FAIL fair_wait_b: got %0d cycles expected at most %0d", gap_b, N - 1); end
    n_checks++; if (pushes != 64) begin n_fail++; $display("FAIL fair_throughput: got %0d pushes expected 64", pushes); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_release();
    test_full_stall();
    test_flush();
    test_single_beat();
    test_reset_mid_burst();
    test_random();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write arbiter that shares one FIFO write port among `NUM_REQ` producers. It sits directly in front of a FIFO instance and drives that FIFO's `push_i`, `data_i` and `flush_i` ports from its own push, data and flush outputs. It observes the FIFO's `full_o`. A granted producer keeps the write port for a burst of up to `MAX_BURST` beats, so multi-beat transfers stay contiguous. Arbitration is then forced so that no producer can starve the others.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of producers; must be ≥2.
- `DATA_WIDTH`, default 32: width of one beat.
- `MAX_BURST`, default 4: maximum consecutive beats per grant; must be ≥1.
- Derived: `IDX_W` = $clog2(`NUM_REQ`).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `flush_i` in 1: flush request.
- `req_valid_i` in `NUM_REQ`: per-producer valid.
- `req_data_i` in `NUM_REQ`*`DATA_WIDTH`: producer k occupies bits [k*`DATA_WIDTH` +: `DATA_WIDTH`].
- `req_ready_o` out `NUM_REQ`: per-producer ready; at most one bit set.
- `fifo_full_i` in 1: the FIFO's full flag.
- `fifo_push_o` out 1: FIFO push.
- `fifo_data_o` out `DATA_WIDTH`: FIFO write data.
- `fifo_flush_o` out 1: FIFO flush.
- `gnt_idx_o` out `IDX_W`: index of the current or candidate grant.
- `busy_o` out 1: high while a burst is locked.

## Operation
Registered state:
- FSM state: `IDLE` or `BURST`.
- `rr_ptr` (`IDX_W` bits).
- `lock_idx` (`IDX_W` bits).
- `beat_cnt`: wide enough for `MAX_BURST`.

IDLE:
- Winner = first k with `req_valid_i`[k]=1, searching from `rr_ptr` upward with wrap.
- If a winner exists, `fifo_full_i`=0 and `flush_i`=0:
  - `req_ready_o`[winner]=1, `fifo_push_o`=1, `fifo_data_o`=data of winner.
  - If `MAX_BURST`=1: `rr_ptr` ← (winner+1) mod `NUM_REQ`; stay in IDLE.
  - Otherwise: `lock_idx` ← winner, `beat_cnt` ← 1, go to BURST.
- If a winner exists but `fifo_full_i`=1: no push, no state change.
- `gnt_idx_o` = winner, or `rr_ptr` if no producer is valid.

BURST (only `lock_idx` can be served):
- `req_valid_i`[lock]=1 and `fifo_full_i`=0:
  - Push the locked producer's data; `beat_cnt` +1.
  - If `beat_cnt`+1 = `MAX_BURST`: `rr_ptr` ← lock+1 mod `NUM_REQ`, go to IDLE.
- `req_valid_i`[lock]=1 and `fifo_full_i`=1: stall. No push, `beat_cnt` held, lock kept.
- `req_valid_i`[lock]=0: release. No push this cycle, `rr_ptr` ← lock+1 mod `NUM_REQ`, go to IDLE.
- Other producers see ready=0 throughout.
- `gnt_idx_o` = `lock_idx`; `busy_o` = 1.

Flush (highest priority):
- `fifo_flush_o` = `flush_i`, a combinational pass-through.
- While `flush_i`=1: `fifo_push_o`=0 and all ready bits are 0.
- Next state is IDLE with `beat_cnt` ← 0; `rr_ptr` is unchanged.

Invariants:
- `fifo_push_o` = OR of (`req_valid_i` & `req_ready_o`).
- `fifo_push_o` is never 1 while `fifo_full_i`=1.
- No beat is ever lost or duplicated.

Reset:
- State IDLE; `rr_ptr`, `lock_idx` and `beat_cnt` are 0.
- `busy_o`=0 and `gnt_idx_o`=0.
- `req_ready_o`, `fifo_push_o` and `fifo_flush_o` follow the combinational rules; all are 0 while inputs are idle.

## Timing
- Zero-cycle path from request to push: ready, push and data are combinational from `req_valid_i`, `fifo_full_i`, `flush_i` and the registered state.
- Ready may depend on valid. Producers must not make valid depend on ready.
- A beat transfers on the rising clock edge when valid and ready are both 1.
- A burst occupies at most `MAX_BURST` consecutive pushing cycles; full-stall cycles do not count.
- Release and burst-end both take effect at the clock edge. Re-arbitration happens in the following cycle.
- Asserting reset mid-burst returns to IDLE immediately. Pushes in progress are dropped; the producer keeps valid high and retries.
- Fairness bound: with every producer continuously valid and the FIFO never full, a producer waits at most (`NUM_REQ`-1)*`MAX_BURST` cycles for a grant.

## Test plan
Defaults apply unless stated: `NUM_REQ`=4, `MAX_BURST`=4.
- Reset, all inputs 0 → `req_ready_o`=0, `fifo_push_o`=0, `gnt_idx_o`=0, `busy_o`=0, `fifo_flush_o`=0.
- Producers 0 and 2 continuously valid with incrementing data, full=0 → pushes 0,0,0,0,2,2,2,2,0,… in consecutive cycles; data order is preserved per producer.
- Producer 1 valid for 2 beats, then low; producer 3 valid → P1 pushes 2 beats, one idle cycle, then P3 is granted (`rr_ptr`=2).
- During P0's 2nd beat, full=1 for 3 cycles → push=0 and lock held for those cycles; then beats 3 and 4 complete, then rotation.
- `flush_i`=1 for 1 cycle during a burst → `fifo_flush_o`=1, push=0, ready=0; next cycle IDLE and `busy_o`=0, with `rr_ptr` unchanged.
- `MAX_BURST`=1, all 4 producers valid → grants 0,1,2,3,0 on successive cycles with `busy_o`=0 throughout.
